// File: rtl/serial_endpoint_if.sv
// Processor-side byte-serial port of the endpoint: a TX write strobe with ready flag,
// and a show-ahead RX head byte with valid flag and pop strobe.
interface serial_endpoint_if;
    logic [7:0] cpu_data_in;
    logic       cpu_wren_in;
    logic       cpu_ready_out;
    logic [7:0] cpu_data_out;
    logic       cpu_valid_out;
    logic       cpu_rden_in;

    // Processor side drives strobes and write data.
    modport master (
        output cpu_data_in,
        output cpu_wren_in,
        output cpu_rden_in,
        input  cpu_ready_out,
        input  cpu_data_out,
        input  cpu_valid_out
    );

    // Endpoint side answers with flow-control flags and the RX head byte.
    modport slave (
        input  cpu_data_in,
        input  cpu_wren_in,
        input  cpu_rden_in,
        output cpu_ready_out,
        output cpu_data_out,
        output cpu_valid_out
    );
endinterface

// File: rtl/serial_endpoint.sv
// Byte-serial IO endpoint: processor writes feed an 8N1 UART transmitter through a TX FIFO,
// and received 8N1 frames are queued in a show-ahead RX FIFO that the processor pops.
module serial_endpoint #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    serial_endpoint_if.slave cpu,
    input  logic             uart_rx_in,
    output logic             uart_tx_out,
    output logic             rx_overrun_out,
    output logic             rx_frame_err_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // Extra pointer MSB tells a full buffer apart from an empty one.
    function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d;
    logic [PW-1:0] tx_rptr_q, tx_rptr_d;
    logic          tx_ready_q, tx_ready_d;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_push;
    logic          tx_pop;
    logic [7:0]    tx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = ptr_full(tx_wptr_q, tx_rptr_q);
    assign tx_push  = cpu.cpu_wren_in && !tx_full;
    assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

    always_comb begin
        tx_wptr_d  = tx_wptr_q + PW'(tx_push);
        tx_rptr_d  = tx_rptr_q + PW'(tx_pop);
        tx_ready_d = !ptr_full(tx_wptr_d, tx_rptr_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q[AW-1:0]] <= cpu.cpu_data_in;
        end
    end

    assign cpu.cpu_ready_out = tx_ready_q;

    // ------------------------------------------------------------------
    // TX serializer
    // ------------------------------------------------------------------
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    // Chain straight into the next start bit so queued bytes leave gap-free.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_line_d  = 1'b0;
                        tx_state_d = TX_START;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign uart_tx_out = tx_line_q;

    // ------------------------------------------------------------------
    // RX synchronizer and deserializer
    // ------------------------------------------------------------------
    logic          rx_sync1_q, rx_sync2_q;
    logic          rx_line;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_overrun_q, rx_overrun_d;
    logic          rx_frame_err_q, rx_frame_err_d;
    logic          rx_bit_end;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_empty;
    logic          rx_full;

    assign rx_line    = rx_sync2_q;
    assign rx_bit_end = (rx_cnt_q == BIT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= uart_rx_in;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    always_comb begin
        rx_state_d     = rx_state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_overrun_d   = rx_overrun_q;
        rx_frame_err_d = rx_frame_err_q;
        rx_push        = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_line) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: a line back at 1 means a glitch, not a start bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_line) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rx_line) begin
                        rx_state_d = RX_IDLE;
                        if (!rx_full || rx_pop) begin
                            rx_push = 1'b1;
                        end else begin
                            rx_overrun_d = 1'b1;
                        end
                    end else begin
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_line) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= 3'd0;
            rx_shift_q     <= 8'h00;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    assign rx_overrun_out   = rx_overrun_q;
    assign rx_frame_err_out = rx_frame_err_q;

    // ------------------------------------------------------------------
    // RX FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_wptr_d;
    logic [PW-1:0] rx_rptr_q, rx_rptr_d;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = ptr_full(rx_wptr_q, rx_rptr_q);
    assign rx_pop   = cpu.cpu_rden_in && !rx_empty;

    always_comb begin
        rx_wptr_d = rx_wptr_q + PW'(rx_push);
        rx_rptr_d = rx_rptr_q + PW'(rx_pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
        end
    end

    // When full, the write slot is the head being popped this cycle, so overwriting it is safe.
    always_ff @(posedge clock) begin
        if (rx_push) begin
            rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
        end
    end

    assign cpu.cpu_valid_out = !rx_empty;
    assign cpu.cpu_data_out  = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[AW-1:0]];
endmodule

// File: tb/tb_serial_endpoint.sv
// Self-checking bench for serial_endpoint: directed scenarios plus randomized traffic,
// with a line decoder on the TX pin and a queue model of the RX FIFO and sticky flags.
module tb_serial_endpoint;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic clock      = 1'b0;
    logic reset      = 1'b1;
    logic uart_rx_in = 1'b1;
    logic uart_tx_out;
    logic rx_overrun_out;
    logic rx_frame_err_out;

    serial_endpoint_if cpu_if ();

    serial_endpoint #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu              (cpu_if),
        .uart_rx_in       (uart_rx_in),
        .uart_tx_out      (uart_tx_out),
        .rx_overrun_out   (rx_overrun_out),
        .rx_frame_err_out (rx_frame_err_out)
    );

    always #5 clock = ~clock;

    int     errors = 0;
    int     checks = 0;
    longint cycle  = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // TX line decoder: samples each bit at its centre, counted from the first low sample.
    logic       mon_busy  = 1'b0;
    int         mon_t     = 0;
    logic [7:0] mon_byte  = 8'h00;
    longint     mon_start = 0;
    logic [7:0] tx_seen_q[$];
    longint     tx_start_q[$];

    always @(negedge clock) begin
        if (!reset) begin
            mon_busy <= 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx_out == 1'b0) begin
                mon_busy  <= 1'b1;
                mon_t     <= 1;
                mon_start <= cycle;
            end
        end else begin
            mon_t <= mon_t + 1;
            if (mon_t % CPB == CPB / 2) begin
                if (mon_t / CPB == 0) begin
                    check("tx_start_bit", uart_tx_out, 0);
                end else if (mon_t / CPB <= 8) begin
                    mon_byte[mon_t / CPB - 1] <= uart_tx_out;
                end else begin
                    check("tx_stop_bit", uart_tx_out, 1);
                    tx_seen_q.push_back(mon_byte);
                    tx_start_q.push_back(mon_start);
                    mon_busy <= 1'b0;
                    $display("uart tx frame %02h started at cycle %0d", mon_byte, mon_start);
                end
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b0;
        uart_rx_in = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tx_seen_q.delete();
        tx_start_q.delete();
    endtask

    task automatic cpu_write(input logic [7:0] b);
        cpu_if.cpu_data_in = b;
        cpu_if.cpu_wren_in = 1'b1;
        @(negedge clock);
        cpu_if.cpu_wren_in = 1'b0;
        $display("cpu write %02h", b);
    endtask

    task automatic cpu_pop(output logic [7:0] b);
        b = cpu_if.cpu_data_out;
        cpu_if.cpu_rden_in = 1'b1;
        @(negedge clock);
        cpu_if.cpu_rden_in = 1'b0;
        $display("cpu pop %02h", b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_in = bits[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx_in = 1'b1;
        $display("uart rx frame %02h stop=%0b", b, stop_bit);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_seen_q.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("tx_frame_count", tx_seen_q.size(), n);
    endtask

    logic [9:0] seq41;
    logic [7:0] b;
    logic [7:0] rb;
    int         same;
    int         rk;
    int         k;
    int         r;
    int         n;
    logic [7:0] sent[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_ferr;

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_if.cpu_data_in = 8'h00;
        cpu_if.cpu_wren_in = 1'b0;
        cpu_if.cpu_rden_in = 1'b0;
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_tx_line", uart_tx_out, 1);
        check("rst_ready", cpu_if.cpu_ready_out, 1);
        check("rst_valid", cpu_if.cpu_valid_out, 0);
        check("rst_data", cpu_if.cpu_data_out, 8'h00);
        check("rst_overrun", rx_overrun_out, 0);
        check("rst_frame_err", rx_frame_err_out, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // One byte out: exact waveform of 8'h41.
        seq41 = 10'b1010000010;
        cpu_write(8'h41);
        check("tx41_not_yet_low", uart_tx_out, 1);
        for (int j = 0; j < 10; j++) begin
            same = 0;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clock);
                if (uart_tx_out === seq41[j]) same++;
            end
            check($sformatf("tx41_bit%0d_samples", j), same, CPB);
        end
        same = 0;
        for (int c = 0; c < 2 * CPB; c++) begin
            @(negedge clock);
            if (uart_tx_out === 1'b1) same++;
        end
        check("tx41_idle_high", same, 2 * CPB);
        wait_tx(1, 10);
        check("tx41_decoded", tx_seen_q.size() > 0 ? tx_seen_q[0] : 8'hxx, 8'h41);
        tx_seen_q.delete();
        tx_start_q.delete();

        // TX full: 10 back-to-back writes, the 10th is dropped.
        for (int i = 0; i < 10; i++) begin
            cpu_write(8'(i));
            if (i == 7) check("tx_ready_after_8", cpu_if.cpu_ready_out, 1);
            if (i == 8) check("tx_ready_after_9", cpu_if.cpu_ready_out, 0);
        end
        wait_tx(9, 9 * FRAME + 100);
        for (int i = 1; i < 9; i++) begin
            check("tx_frame_spacing", 32'(tx_start_q[i] - tx_start_q[i-1]), FRAME);
        end
        for (int i = 0; i < 9; i++) begin
            check("tx_full_data", tx_seen_q.size() > 0 ? tx_seen_q.pop_front() : 8'hxx, 8'(i));
        end
        repeat (2 * FRAME) @(negedge clock);
        check("tx_dropped_byte_absent", tx_seen_q.size(), 0);
        check("tx_ready_restored", cpu_if.cpu_ready_out, 1);

        // RX receive and pop.
        send_frame(8'hA5, 1'b1);
        check("rx_a5_valid", cpu_if.cpu_valid_out, 1);
        check("rx_a5_data", cpu_if.cpu_data_out, 8'hA5);
        cpu_pop(rb);
        check("rx_a5_valid_after_pop", cpu_if.cpu_valid_out, 0);

        // RX overrun: 9 frames with no reads.
        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
        check("rx_overrun_set", rx_overrun_out, 1);
        for (int i = 0; i < 8; i++) begin
            check("rx_ovr_valid", cpu_if.cpu_valid_out, 1);
            cpu_pop(rb);
            check("rx_ovr_data", rb, 8'h10 + 8'(i));
        end
        check("rx_ovr_drained", cpu_if.cpu_valid_out, 0);

        // Concurrent reads across pointer wrap.
        do_reset();
        sent.delete();
        got_q.delete();
        for (int i = 0; i < 20; i++) sent.push_back(8'($urandom_range(0, 255)));
        fork
            begin
                for (int i = 0; i < 20; i++) send_frame(sent[i], 1'b1);
            end
            begin
                rk = 0;
                while (got_q.size() < 20 && rk < 20 * FRAME + 200) begin
                    if (cpu_if.cpu_valid_out) begin
                        cpu_pop(rb);
                        got_q.push_back(rb);
                    end else begin
                        @(negedge clock);
                    end
                    rk++;
                end
            end
        join
        check("wrap_count", got_q.size(), 20);
        for (int i = 0; i < 20; i++) check("wrap_data", got_q[i], sent[i]);
        check("wrap_no_overrun", rx_overrun_out, 0);

        // RX errors: glitch, bad stop bit, then a good frame.
        uart_rx_in = 1'b0;
        repeat (5) @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("glitch_no_push", cpu_if.cpu_valid_out, 0);
        check("glitch_no_error", rx_frame_err_out, 0);
        send_frame(8'h77, 1'b0);
        repeat (2 * CPB) @(negedge clock);
        check("bad_stop_no_push", cpu_if.cpu_valid_out, 0);
        check("bad_stop_flag", rx_frame_err_out, 1);
        send_frame(8'h3C, 1'b1);
        check("after_err_valid", cpu_if.cpu_valid_out, 1);
        check("after_err_data", cpu_if.cpu_data_out, 8'h3C);
        cpu_pop(rb);

        // Reset mid-frame in both directions.
        send_frame(8'h99, 1'b1);
        cpu_write(8'h00);
        cpu_write(8'h11);
        cpu_write(8'h22);
        uart_rx_in = 1'b0;
        repeat (3 * CPB - 4) @(negedge clock);
        check("pre_reset_tx_low", uart_tx_out, 0);
        check("pre_reset_rx_valid", cpu_if.cpu_valid_out, 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tx_high", uart_tx_out, 1);
        check("async_reset_valid", cpu_if.cpu_valid_out, 0);
        check("async_reset_ready", cpu_if.cpu_ready_out, 1);
        check("async_reset_data", cpu_if.cpu_data_out, 8'h00);
        check("async_reset_frame_err", rx_frame_err_out, 0);
        check("async_reset_overrun", rx_overrun_out, 0);
        uart_rx_in = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tx_seen_q.delete();
        tx_start_q.delete();
        repeat (2 * FRAME) @(negedge clock);
        check("post_reset_tx_silent", tx_seen_q.size(), 0);
        check("post_reset_rx_empty", cpu_if.cpu_valid_out, 0);
        cpu_write(8'h55);
        send_frame(8'h55, 1'b1);
        check("post_reset_rx_valid", cpu_if.cpu_valid_out, 1);
        check("post_reset_rx_data", cpu_if.cpu_data_out, 8'h55);
        cpu_pop(rb);
        wait_tx(1, FRAME);
        check("post_reset_tx_data", tx_seen_q.size() > 0 ? tx_seen_q.pop_front() : 8'hxx, 8'h55);

        // Randomized TX traffic, flow-controlled on cpu_ready_out.
        exp_q.delete();
        tx_seen_q.delete();
        tx_start_q.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            k = 0;
            while (!cpu_if.cpu_ready_out && k < 2 * FRAME) begin
                @(negedge clock);
                k++;
            end
            check("tx_rand_ready", cpu_if.cpu_ready_out, 1);
            cpu_write(b);
            exp_q.push_back(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clock);
        end
        wait_tx(16, 17 * FRAME);
        for (int i = 0; i < 16; i++) begin
            check("tx_rand_data", tx_seen_q.size() > 0 ? tx_seen_q.pop_front() : 8'hxx, exp_q[i]);
        end

        // Randomized RX traffic against a queue model.
        do_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 255));
            if (r < 6) begin
                send_frame(b, 1'b1);
                if (mq.size() < DEPTH) mq.push_back(b);
                else m_ovr = 1'b1;
            end else if (r == 6) begin
                send_frame(b, 1'b0);
                m_ferr = 1'b1;
                repeat (2 * CPB) @(negedge clock);
            end else begin
                n = $urandom_range(1, 4);
                for (int p = 0; p < n; p++) begin
                    check("rx_rand_valid", cpu_if.cpu_valid_out, mq.size() > 0);
                    cpu_pop(rb);
                    if (mq.size() > 0) check("rx_rand_data", rb, mq.pop_front());
                end
            end
            check("rx_rand_overrun", rx_overrun_out, m_ovr);
            check("rx_rand_frame_err", rx_frame_err_out, m_ferr);
            check("rx_rand_valid_state", cpu_if.cpu_valid_out, mq.size() > 0);
        end
        while (mq.size() > 0) begin
            check("rx_drain_valid", cpu_if.cpu_valid_out, 1);
            cpu_pop(rb);
            check("rx_drain_data", rb, mq.pop_front());
        end
        check("rx_drain_empty", cpu_if.cpu_valid_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
